// File: rtl/mips_reset_sequencer_if.sv
// rtl/mips_reset_sequencer_if.sv - control/status bundle between the reset sequencer and the MIPS core
interface mips_reset_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);
    logic              restart_req;
    logic              halt;
    logic              heartbeat;
    logic [NUM_CH-1:0] cpu_reset;
    logic              run;
    logic              done;
    logic [CNT_W-1:0]  cycle_count;
    logic              wdog_fired;

    modport master (
        input  restart_req, halt, heartbeat,
        output cpu_reset, run, done, cycle_count, wdog_fired
    );

    modport slave (
        output restart_req, halt, heartbeat,
        input  cpu_reset, run, done, cycle_count, wdog_fired
    );
endinterface

// File: rtl/mips_reset_sequencer.sv
// rtl/mips_reset_sequencer.sv - staggered reset release and bounded run control; optional MIPS_RSTSEQ_WATCHDOG_EN
module mips_reset_sequencer #(
    parameter int NUM_CH      = 2,
    parameter int HOLD_CYCLES = 2,
    parameter int STAGGER     = 1,
    parameter int RUN_CYCLES  = 9,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_reset_sequencer_if.master bus
);
    typedef enum logic [1:0] {ASSERT, RELEASE, RUN, DONE} state_t;

    localparam logic [31:0]      HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0]      REL_LAST  = 32'((NUM_CH - 1) * STAGGER);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

    state_t            state;
    logic [31:0]       hold_cnt;
    logic [31:0]       rel_cnt;
    logic [NUM_CH-1:0] cpu_reset_q;
    logic              run_q;
    logic              done_q;
    logic [CNT_W-1:0]  cycle_count_q;
    logic              wdog_trip;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ASSERT;
            hold_cnt      <= '0;
            rel_cnt       <= '0;
            cpu_reset_q   <= '1;
            run_q         <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
        end else if (bus.restart_req || wdog_trip) begin
            state         <= ASSERT;
            hold_cnt      <= '0;
            rel_cnt       <= '0;
            cpu_reset_q   <= '1;
            run_q         <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            case (state)
                ASSERT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= RELEASE;
                        rel_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                RELEASE: begin
                    // channel i drops once i*STAGGER release cycles have elapsed
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (rel_cnt == 32'(i * STAGGER)) cpu_reset_q[i] <= 1'b0;
                    end
                    if (rel_cnt == REL_LAST) begin
                        state         <= RUN;
                        run_q         <= 1'b1;
                        cycle_count_q <= '0;
                    end else begin
                        rel_cnt <= rel_cnt + 32'd1;
                    end
                end
                RUN: begin
                    if (bus.halt || (RUN_CYCLES != 0 && cycle_count_q == RUN_LAST)) begin
                        state       <= DONE;
                        run_q       <= 1'b0;
                        done_q      <= 1'b1;
                        cpu_reset_q <= '1;
                    end else if (cycle_count_q != '1) begin
                        cycle_count_q <= cycle_count_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MIPS_RSTSEQ_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);

    logic [31:0] wdog_cnt;
    logic        wdog_fired_q;

    assign wdog_trip = (state == RUN) && !bus.heartbeat && (wdog_cnt == WDOG_LAST);

    // an explicit restart on the same edge wins, so it does not count as a watchdog event
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_cnt     <= '0;
            wdog_fired_q <= 1'b0;
        end else begin
            if (wdog_trip && !bus.restart_req) wdog_fired_q <= 1'b1;
            if (state != RUN || bus.heartbeat) wdog_cnt <= '0;
            else wdog_cnt <= wdog_cnt + 32'd1;
        end
    end

    assign bus.wdog_fired = wdog_fired_q;
`else
    localparam int unused_wdog_cycles = WDOG_CYCLES;
    logic unused_heartbeat;

    assign unused_heartbeat = bus.heartbeat;
    assign wdog_trip        = 1'b0;
    assign bus.wdog_fired   = 1'b0;
`endif

    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.run         = run_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_mips_reset_sequencer.sv
// tb/tb_mips_reset_sequencer.sv - directed and randomized checks of mips_reset_sequencer
module tb_mips_reset_sequencer;
    localparam int NUM_CH = 2, HOLD = 2, STAGGER = 1, RUN_CYCLES = 9, CNT_W = 32, WDOG = 8;
    // number of post-reset edges after which the first RUN cycle is visible
    localparam int R = HOLD + (NUM_CH - 1) * STAGGER + 1;

    logic clk = 1'b0;
    logic reset;
    logic reset_b;

    always #5 clk = ~clk;

    mips_reset_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus_a ();
    mips_reset_sequencer_if #(.NUM_CH(4), .CNT_W(4)) bus_b ();

    mips_reset_sequencer #(
        .NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .STAGGER(STAGGER),
        .RUN_CYCLES(RUN_CYCLES), .CNT_W(CNT_W), .WDOG_CYCLES(WDOG)
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a.master));

    mips_reset_sequencer #(
        .NUM_CH(4), .HOLD_CYCLES(2), .STAGGER(0),
        .RUN_CYCLES(0), .CNT_W(4), .WDOG_CYCLES(64)
    ) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b.master));

    int n_checks = 0;
    int n_pass   = 0;

    int seq_t  = 0;
    bit fin    = 0;
    int fin_cc = 0;
    int quiet  = 0;
    bit fired  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_step(input logic r, input logic rq, input logic h, input logic hb);
        int cc;
        bit wd;
        wd = 0;
        if (!r) begin
            seq_t = 0; fin = 0; fin_cc = 0; quiet = 0; fired = 0;
        end else if (rq) begin
            seq_t = 0; fin = 0;
        end else if (fin) begin
        end else if (seq_t >= R) begin
            cc = seq_t - R;
`ifdef MIPS_RSTSEQ_WATCHDOG_EN
            wd = !hb && (quiet == WDOG - 1);
            quiet = hb ? 0 : quiet + 1;
`endif
            if (wd) begin
                seq_t = 0; fired = 1;
            end else if (h || (RUN_CYCLES != 0 && cc == RUN_CYCLES - 1)) begin
                fin = 1; fin_cc = cc;
            end else begin
                seq_t++;
            end
        end else begin
            seq_t++;
            if (seq_t == R) quiet = 0;
        end
    endtask

    task automatic compare_a();
        logic [NUM_CH-1:0] exp_rst;
        logic [CNT_W-1:0]  exp_cc;
        for (int i = 0; i < NUM_CH; i++) exp_rst[i] = fin || (seq_t <= HOLD + i * STAGGER);
        exp_cc = fin ? CNT_W'(fin_cc) : (seq_t >= R ? CNT_W'(seq_t - R) : '0);
        check("cpu_reset", bus_a.cpu_reset, exp_rst);
        check("run", bus_a.run, !fin && seq_t >= R);
        check("done", bus_a.done, fin);
        check("cycle_count", bus_a.cycle_count, exp_cc);
        check("wdog_fired", bus_a.wdog_fired, fired);
    endtask

    task automatic cycle(input logic r, input logic rq, input logic h, input logic hb);
        reset = r;
        bus_a.restart_req = rq;
        bus_a.halt = h;
        bus_a.heartbeat = hb;
        model_step(r, rq, h, hb);
        @(negedge clk);
        compare_a();
    endtask

    initial begin
        reset_b = 1'b0;
        bus_b.restart_req = 1'b0;
        bus_b.halt = 1'b0;
        bus_b.heartbeat = 1'b1;

        // default sequence and budget expiry
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("t1_reset_cpu_reset", bus_a.cpu_reset, 2'b11);
        check("t1_reset_count", bus_a.cycle_count, 0);
        cycle(1, 0, 0, 1);
        check("t1_e0", bus_a.cpu_reset, 2'b11);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("t1_e2", bus_a.cpu_reset, 2'b10);
        cycle(1, 0, 0, 1);
        check("t1_e3_rst", bus_a.cpu_reset, 2'b00);
        check("t1_e3_run", bus_a.run, 1'b1);
        for (int k = 0; k < 8; k++) cycle(1, 0, 0, 1);
        check("t1_last_count", bus_a.cycle_count, 8);
        cycle(1, 0, 0, 1);
        check("t1_done", bus_a.done, 1'b1);
        check("t1_done_count", bus_a.cycle_count, 8);
        check("t1_done_rst", bus_a.cpu_reset, 2'b11);

        // halt mid-run
        cycle(1, 1, 0, 1);
        for (int k = 0; k < 8; k++) cycle(1, 0, 0, 1);
        check("t2_count4", bus_a.cycle_count, 4);
        cycle(1, 0, 1, 1);
        check("t2_done", bus_a.done, 1'b1);
        check("t2_run", bus_a.run, 1'b0);
        check("t2_count", bus_a.cycle_count, 4);

        // restart during release
        cycle(1, 1, 0, 1);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 1);
        check("t3_ch0_low", bus_a.cpu_reset, 2'b10);
        cycle(1, 1, 0, 1);
        check("t3_restart", bus_a.cpu_reset, 2'b11);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("t3_hold", bus_a.cpu_reset, 2'b11);
        cycle(1, 0, 0, 1);
        check("t3_ch0", bus_a.cpu_reset, 2'b10);
        cycle(1, 0, 0, 1);
        check("t3_run", bus_a.run, 1'b1);

        // reset mid-run
        for (int k = 0; k < 5; k++) cycle(1, 0, 0, 1);
        check("t4_count5", bus_a.cycle_count, 5);
        cycle(0, 0, 0, 1);
        check("t4_rst", bus_a.cpu_reset, 2'b11);
        check("t4_run", bus_a.run, 1'b0);
        check("t4_count", bus_a.cycle_count, 0);
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 1);
        check("t4_rerun", bus_a.run, 1'b1);

`ifdef MIPS_RSTSEQ_WATCHDOG_EN
        // watchdog: silent core trips, regular heartbeat does not
        cycle(1, 1, 0, 0);
        for (int k = 0; k < 4 + 7; k++) cycle(1, 0, 0, 0);
        check("t6_pre_trip", bus_a.cycle_count, 7);
        cycle(1, 0, 0, 0);
        check("t6_trip_rst", bus_a.cpu_reset, 2'b11);
        check("t6_trip_run", bus_a.run, 1'b0);
        check("t6_fired", bus_a.wdog_fired, 1'b1);
        cycle(1, 1, 0, 0);
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) cycle(1, 0, 0, (k % 4) == 3);
        check("t6_hb_run", bus_a.run, 1'b1);
        check("t6_hb_count", bus_a.cycle_count, 8);
`endif

        // randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            cycle($urandom_range(0, 59) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
        end

        // wide, unstaggered, unlimited instance
        reset_b = 1'b0;
        cycle(1, 0, 0, 1);
        check("b_reset_rst", bus_b.cpu_reset, 4'hf);
        reset_b = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cycle(1, 0, 0, 1);
            if (k == 2) check("b_hold", bus_b.cpu_reset, 4'hf);
            if (k == 3) begin
                check("b_all_fall", bus_b.cpu_reset, 4'h0);
                check("b_run", bus_b.run, 1'b1);
                check("b_count0", bus_b.cycle_count, 0);
            end
            if (k == 17) check("b_count14", bus_b.cycle_count, 14);
            if (k == 18) check("b_count15", bus_b.cycle_count, 15);
        end
        check("b_saturated", bus_b.cycle_count, 15);
        check("b_no_done", bus_b.done, 1'b0);
        check("b_still_run", bus_b.run, 1'b1);
        check("b_wdog", bus_b.wdog_fired, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
